// File: rtl/muldiv_pkg.sv
// Shared types and op-decode helpers for the iterative multiply/divide unit.
package muldiv_pkg;

  // RISC-V M-extension funct3 encoding.
  typedef enum logic [2:0] {
    MUL    = 3'b000,
    MULH   = 3'b001,
    MULHSU = 3'b010,
    MULHU  = 3'b011,
    DIV    = 3'b100,
    DIVU   = 3'b101,
    REM    = 3'b110,
    REMU   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  function automatic logic is_div(input op_e op);
    return op inside {DIV, DIVU, REM, REMU};
  endfunction

  function automatic logic a_signed(input op_e op);
    return op inside {MULH, MULHSU, DIV, REM};
  endfunction

  function automatic logic b_signed(input op_e op);
    return op inside {MULH, DIV, REM};
  endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// One radix-2 step: shift-add multiply (mode=0) or restoring divide (mode=1).
// acc holds {hi, lo}; divide leaves remainder in hi and quotient in lo.
module muldiv_iter_core #(
  parameter int XLEN = 32
) (
  input  logic [2*XLEN-1:0] acc,
  input  logic [XLEN-1:0]   operand,
  input  logic              mode,
  output logic [2*XLEN-1:0] acc_next,
  output logic              q_bit
);

  logic [XLEN:0] sum;
  logic [XLEN:0] sh_rem;
  logic [XLEN:0] diff;

  assign sum    = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, operand} : '0);
  assign sh_rem = acc[2*XLEN-1:XLEN-1];
  // Borrow out of the (XLEN+1)-bit subtract means the trial remainder was too small.
  assign diff   = sh_rem - {1'b0, operand};

  always_comb begin
    acc_next = '0;
    q_bit    = 1'b0;
    if (mode) begin
      q_bit    = ~diff[XLEN];
      acc_next = {(q_bit ? diff[XLEN-1:0] : sh_rem[XLEN-1:0]), acc[XLEN-2:0], q_bit};
    end else begin
      acc_next = {sum, acc[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq_unit.sv
// Iterative RV32 M-extension multiply/divide unit, one bit per clock, valid/ready on both sides.
// MULDIV_FAST_MUL_EN selects a single-cycle combinational multiplier for MUL* ops.
module muldiv_seq_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy,
  output logic            div_by_zero
);

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_e            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [2*XLEN-1:0] acc, acc_nxt;
  logic [XLEN-1:0]   opnd;
  op_e               op_q;
  logic              res_neg;
  logic              q_bit;

  op_e               op_in;
  logic              a_neg_in, b_neg_in, res_neg_in;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic              accept, div_zero, div_ovf, special, use_fast, last_step;
  logic [XLEN-1:0]   special_res, final_res, quot, rmd;
  logic [2*XLEN-1:0] prod;

  assign op_in      = op_e'(op);
  assign a_neg_in   = a_signed(op_in) & A[XLEN-1];
  assign b_neg_in   = b_signed(op_in) & B[XLEN-1];
  assign a_mag      = a_neg_in ? -A : A;
  assign b_mag      = b_neg_in ? -B : B;
  // Remainder follows the dividend's sign; everything else follows the XOR of signs.
  assign res_neg_in = (op_in inside {REM, REMU}) ? a_neg_in : (a_neg_in ^ b_neg_in);

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  assign accept    = in_ready && in_valid && !flush;
  assign div_zero  = is_div(op_in) && (B == '0);
  assign div_ovf   = (op_in inside {DIV, REM}) && (A == MIN_NEG) && (B == '1);
  assign special   = div_zero || div_ovf;
  assign last_step = (state == CALC) && (cnt == CNT_W'(XLEN-1));

  always_comb begin
    special_res = '0;
    if (div_zero)
      special_res = (op_in inside {DIV, DIVU}) ? '1 : A;
    else if (div_ovf)
      special_res = (op_in == DIV) ? MIN_NEG : '0;
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod;
  logic [XLEN-1:0]   fast_res;

  // Sign-extended operands make the truncated 2*XLEN product correct for every MUL* variant.
  assign fast_prod = {{XLEN{a_neg_in}}, A} * {{XLEN{b_neg_in}}, B};
  assign fast_res  = (op_in == MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
  assign use_fast  = !is_div(op_in);
`else
  assign use_fast  = 1'b0;
`endif

  muldiv_iter_core #(.XLEN(XLEN)) u_core (
    .acc      (acc),
    .operand  (opnd),
    .mode     (is_div(op_q)),
    .acc_next (acc_nxt),
    .q_bit    (q_bit)
  );

  always_comb begin
    prod      = res_neg ? -acc_nxt : acc_nxt;
    quot      = {acc_nxt[XLEN-1:1], q_bit};
    rmd       = acc_nxt[2*XLEN-1:XLEN];
    final_res = '0;
    case (op_q)
      MUL:                 final_res = prod[XLEN-1:0];
      MULH, MULHSU, MULHU: final_res = prod[2*XLEN-1:XLEN];
      DIV, DIVU:           final_res = res_neg ? -quot : quot;
      default:             final_res = res_neg ? -rmd : rmd;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = (special || use_fast) ? DONE : CALC;
      CALC: begin
        if (flush)          state_nxt = IDLE;
        else if (last_step) state_nxt = DONE;
      end
      DONE: if (flush || out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      acc         <= '0;
      opnd        <= '0;
      op_q        <= MUL;
      res_neg     <= 1'b0;
      result      <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_q        <= op_in;
            res_neg     <= res_neg_in;
            cnt         <= '0;
            div_by_zero <= div_zero;
            // Divide iterates over the dividend; multiply shifts the multiplier (B) out of lo.
            if (is_div(op_in)) begin
              acc  <= {{XLEN{1'b0}}, a_mag};
              opnd <= b_mag;
            end else begin
              acc  <= {{XLEN{1'b0}}, b_mag};
              opnd <= a_mag;
            end
            if (special)
              result <= special_res;
`ifdef MULDIV_FAST_MUL_EN
            else if (use_fast)
              result <= fast_res;
`endif
          end
        end
        CALC: begin
          if (flush) begin
            result      <= '0;
            div_by_zero <= 1'b0;
          end else begin
            acc <= acc_nxt;
            cnt <= cnt + CNT_W'(1);
            if (last_step)
              result <= final_res;
          end
        end
        DONE: begin
          if (flush) begin
            result      <= '0;
            div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq_unit.sv
// Directed and randomized checks of muldiv_seq_unit against a 64-bit arithmetic reference model.
module tb_muldiv_seq_unit;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, flush, out_valid, out_ready, busy, div_by_zero;
  logic [2:0]  op;
  logic [31:0] A, B, result;
  int          total = 0;
  int          passed = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  muldiv_seq_unit dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .op          (op),
    .A           (A),
    .B           (B),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .busy        (busy),
    .div_by_zero (div_by_zero)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // RISC-V M semantics computed with plain 64-bit arithmetic.
  function automatic logic [31:0] ref_res(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, sp;
    longint unsigned ua, ub, up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (o)
      3'd0: begin sp = sa * sb; return sp[31:0]; end
      3'd1: begin sp = sa * sb; return sp[63:32]; end
      3'd2: begin sp = sa * longint'(ub); return sp[63:32]; end
      3'd3: begin up = ua * ub; return up[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        sp = sa / sb; return sp[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        sp = sa % sb; return sp[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res);
    int   lat, exp_lat;
    logic exp_dz, special;
    exp_dz  = o[2] && (b == 32'd0);
    special = exp_dz || ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    exp_lat = special ? 1 : 33;
`ifdef MULDIV_FAST_MUL_EN
    if (!o[2]) exp_lat = 1;
`endif
    chk({tag, "/in_ready"}, 64'(in_ready), 64'd1);
    op = o; A = a; B = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; A = $urandom; B = $urandom; op = 3'($urandom);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "/latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, "/result"}, 64'(result), 64'(exp_res));
    chk({tag, "/div_by_zero"}, 64'(div_by_zero), 64'(exp_dz));
    @(posedge clk); #1;
  endtask

  initial begin
    int   lat;
    logic seen;
    rst = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    op = 3'd0; A = '0; B = '0;
    #1 rst = 1'b1;
    #2;
    chk("reset/in_ready", 64'(in_ready), 64'd1);
    chk("reset/out_valid", 64'(out_valid), 64'd0);
    chk("reset/busy", 64'(busy), 64'd0);
    chk("reset/result", 64'(result), 64'd0);
    chk("reset/div_by_zero", 64'(div_by_zero), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    run_op("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    chk("next_accept", 64'(in_ready), 64'd1);
    run_op("mulh", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    run_op("mul", 3'd0, 32'hFFFF_FFF9, 32'd3, 32'hFFFF_FFEB);
    run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF);
    run_op("div", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    run_op("rem", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    run_op("divu", 3'd5, 32'hFFFF_FFFF, 32'd16, 32'h0FFF_FFFF);
    run_op("div0", 3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF);
    run_op("remu0", 3'd7, 32'd5, 32'd0, 32'd5);
    run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);

    // Back-pressure: result must hold while the consumer stalls.
    out_ready = 1'b0;
    op = 3'd5; A = 32'd1000; B = 32'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; A = $urandom; B = $urandom;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("bp/latency", 64'(lat), 64'd33);
    for (int i = 0; i < 5; i++) begin
      chk("bp/result", 64'(result), 64'd333);
      chk("bp/out_valid", 64'(out_valid), 64'd1);
      chk("bp/in_ready", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp/release_out_valid", 64'(out_valid), 64'd0);
    chk("bp/release_in_ready", 64'(in_ready), 64'd1);

    // Flush in CALC cycle 10.
    op = 3'd4; A = 32'd12345; B = 32'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    chk("flush/busy_before", 64'(busy), 64'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush/in_ready", 64'(in_ready), 64'd1);
    chk("flush/busy", 64'(busy), 64'd0);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("flush/out_valid_never", 64'(seen), 64'd0);

    // Flush in IDLE wins over a simultaneous request.
    op = 3'd0; A = 32'd9; B = 32'd9; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    chk("idle_flush/busy", 64'(busy), 64'd0);

    // Reset pulsed mid-operation, CALC cycle 15.
    op = 3'd0; A = 32'd77; B = 32'd55; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (14) begin @(posedge clk); #1; end
    chk("rst_mid/busy_before", 64'(busy), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid/in_ready", 64'(in_ready), 64'd1);
    chk("rst_mid/out_valid", 64'(out_valid), 64'd0);
    chk("rst_mid/busy", 64'(busy), 64'd0);
    chk("rst_mid/result", 64'(result), 64'd0);
    chk("rst_mid/div_by_zero", 64'(div_by_zero), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    run_op("divu_after_rst", 3'd5, 32'd100, 32'd7, 32'd14);

    for (int i = 0; i < 40; i++) begin
      logic [2:0]  ro;
      logic [31:0] ra, rb;
      ro = 3'($urandom_range(0, 7));
      ra = pick_operand();
      rb = pick_operand();
      run_op("rnd", ro, ra, rb, ref_res(ro, ra, rb));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
